// File: rtl/rx_timer_pkg.sv
// Shared types and limits for the RX bit timer.
// The PARITY state exists only when RX_BIT_TIMER_PARITY_EN is defined.
package rx_timer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef RX_BIT_TIMER_PARITY_EN
      PARITY,
`endif
      STOP,
      DONE
   } state_t;

   localparam int MIN_PERIOD = 2;
   localparam int MIN_SIZE   = 1;

endpackage

// File: rtl/bit_phase_counter.sv
// Phase counter: runs 1..term, reloads to 1 on the terminal cycle.
// Counts never pass term, so a full-scale term cannot wrap through 0.
module bit_phase_counter #(
   parameter int CNT_W = 14
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] term,
   output logic             hit
);

   logic [CNT_W-1:0] cnt;

   assign hit = (cnt == term);

   always_ff @(posedge clk) begin
      if (clr)
         cnt <= '0;
      else if (en)
         cnt <= hit ? CNT_W'(1) : cnt + CNT_W'(1);
   end

endmodule

// File: rtl/rx_bit_timer.sv
// Receive bit timer: start/data/stop centre strobes for one packet.
// Parity support is compiled in with RX_BIT_TIMER_PARITY_EN.
module rx_bit_timer
   import rx_timer_pkg::*;
#(
   parameter int CNT_W  = 14,
   parameter int SIZE_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable_timer,
   input  logic [SIZE_W-1:0] data_size,
   input  logic [CNT_W-1:0]  bit_period,
   input  logic              two_stop,
`ifdef RX_BIT_TIMER_PARITY_EN
   input  logic              parity_en,
   output logic              parity_strobe,
`endif
   output logic              start_strobe,
   output logic              shift_enable,
   output logic              stop_strobe,
   output logic [SIZE_W-1:0] bit_index,
   output logic              packet_done,
   output logic              busy
);

   state_t state, nxt;

   logic [CNT_W-1:0]  p_q, p_in, term;
   logic [SIZE_W-1:0] d_q, d_in, bit_q;
   logic              two_q, stop_q, hit, last_bit;
`ifdef RX_BIT_TIMER_PARITY_EN
   logic              par_q;
`endif

   assign p_in = (bit_period < CNT_W'(MIN_PERIOD)) ?
                 CNT_W'(MIN_PERIOD) : bit_period;
   assign d_in = (data_size < SIZE_W'(MIN_SIZE)) ?
                 SIZE_W'(MIN_SIZE) : data_size;

   // Start bit is sampled half a period in; p_q >= 2 keeps this >= 1
   assign term     = (state == START) ? (p_q >> 1) : p_q;
   assign last_bit = (bit_q == d_q - SIZE_W'(1));

   bit_phase_counter #(.CNT_W(CNT_W)) u_phase (
      .clk  (clk),
      .clr  (rst | ~enable_timer | (state == DONE)),
      .en   ((state != IDLE) | enable_timer),
      .term (term),
      .hit  (hit)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (!enable_timer)
         nxt = IDLE;
      else
         unique case (state)
            IDLE:  nxt = START;
            START: if (hit) nxt = DATA;
            DATA:
               if (hit && last_bit) begin
`ifdef RX_BIT_TIMER_PARITY_EN
                  nxt = par_q ? PARITY : STOP;
`else
                  nxt = STOP;
`endif
               end
`ifdef RX_BIT_TIMER_PARITY_EN
            PARITY: if (hit) nxt = STOP;
`endif
            STOP:
               if (hit && (!two_q || stop_q))
                  nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
         endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q   <= CNT_W'(MIN_PERIOD);
         d_q   <= SIZE_W'(MIN_SIZE);
         two_q <= 1'b0;
`ifdef RX_BIT_TIMER_PARITY_EN
         par_q <= 1'b0;
`endif
      end else if (state == IDLE && enable_timer) begin
         p_q   <= p_in;
         d_q   <= d_in;
         two_q <= two_stop;
`ifdef RX_BIT_TIMER_PARITY_EN
         par_q <= parity_en;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !enable_timer) begin
         bit_q  <= '0;
         stop_q <= 1'b0;
      end else begin
         if (state != DATA)
            bit_q <= '0;
         else if (hit)
            bit_q <= last_bit ? '0 : bit_q + SIZE_W'(1);
         if (state != STOP)
            stop_q <= 1'b0;
         else if (hit)
            stop_q <= 1'b1;
      end
   end

   always_comb begin
      start_strobe = 1'b0;
      shift_enable = 1'b0;
      stop_strobe  = 1'b0;
      packet_done  = 1'b0;
`ifdef RX_BIT_TIMER_PARITY_EN
      parity_strobe = 1'b0;
`endif
      busy      = (state != IDLE);
      bit_index = (state == DATA) ? bit_q : '0;
      if (enable_timer)
         unique case (state)
            START: start_strobe = hit;
            DATA:  shift_enable = hit;
`ifdef RX_BIT_TIMER_PARITY_EN
            PARITY: parity_strobe = hit;
`endif
            STOP:    stop_strobe = hit;
            DONE:    packet_done = 1'b1;
            default: ;
         endcase
   end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Scoreboard bench for rx_bit_timer: expected strobe events are queued
// from packet arithmetic and popped by a monitor as the DUT emits them.
module tb_rx_bit_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable_timer;
   logic [3:0]  data_size;
   logic [13:0] bit_period;
   logic        two_stop;
   logic        start_strobe;
   logic        shift_enable;
   logic        stop_strobe;
   logic [3:0]  bit_index;
   logic        packet_done;
   logic        busy;
`ifdef RX_BIT_TIMER_PARITY_EN
   logic        parity_en;
   logic        parity_strobe;
`endif

   rx_bit_timer dut (
      .clk          (clk),
      .rst          (rst),
      .enable_timer (enable_timer),
      .data_size    (data_size),
      .bit_period   (bit_period),
      .two_stop     (two_stop),
`ifdef RX_BIT_TIMER_PARITY_EN
      .parity_en    (parity_en),
      .parity_strobe(parity_strobe),
`endif
      .start_strobe (start_strobe),
      .shift_enable (shift_enable),
      .stop_strobe  (stop_strobe),
      .bit_index    (bit_index),
      .packet_done  (packet_done),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   localparam int K_START = 0;
   localparam int K_SHIFT = 1;
   localparam int K_PAR   = 2;
   localparam int K_STOP  = 3;
   localparam int K_DONE  = 4;

   typedef struct {
      int cyc;
      int kind;
      int idx;
   } ev_t;

   ev_t q[$];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0d: got %0d want %0d",
                  name, cyc + 1, act, exp);
      end
   endtask

   // Reference timeline of one packet, enable sampled at edge k
   task automatic push_pkt(input int k, input int p, input int ds,
                           input bit two, input bit par,
                           output int done);
      int pp, d, t;
      pp = (p < 2) ? 2 : p;
      d  = (ds == 0) ? 1 : ds;
      t  = k + pp / 2;
      q.push_back('{t, K_START, 0});
      for (int i = 0; i < d; i++) begin
         t += pp;
         q.push_back('{t, K_SHIFT, i});
      end
      if (par) begin
         t += pp;
         q.push_back('{t, K_PAR, 0});
      end
      t += pp;
      q.push_back('{t, K_STOP, 0});
      if (two) begin
         t += pp;
         q.push_back('{t, K_STOP, 0});
      end
      done = t + 1;
      q.push_back('{done, K_DONE, 0});
   endtask

   task automatic purge_from(input int c);
      while (q.size() > 0 && q[q.size()-1].cyc >= c)
         void'(q.pop_back());
   endtask

   task automatic go_to(input int lbl);
      while (cyc + 1 < lbl) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin : monitor
      int cur, n, kind;
      ev_t e;
      cur = cyc + 1;
      while (q.size() > 0 && q[0].cyc < cur) begin
         e = q.pop_front();
         total++;
         bad++;
         $display("FAIL missed kind=%0d @%0d: got none want event",
                  e.kind, e.cyc);
      end
      n = 0;
      kind = -1;
      if (start_strobe === 1'b1) begin n++; kind = K_START; end
      if (shift_enable === 1'b1) begin n++; kind = K_SHIFT; end
      if (stop_strobe  === 1'b1) begin n++; kind = K_STOP;  end
      if (packet_done  === 1'b1) begin n++; kind = K_DONE;  end
`ifdef RX_BIT_TIMER_PARITY_EN
      if (parity_strobe === 1'b1) begin n++; kind = K_PAR; end
`endif
      if (n > 1)
         chk("exclusive", n, 1);
      if (n >= 1) begin
         if (q.size() == 0 || q[0].cyc != cur) begin
            total++;
            bad++;
            $display("FAIL unexpected kind=%0d @%0d: got event want none",
                     kind, cur);
         end else begin
            e = q.pop_front();
            chk("kind", kind, e.kind);
            if (e.kind == K_SHIFT)
               chk("bit_index", bit_index, e.idx);
         end
      end
   end

   task automatic chk_quiet(input string name);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_idx"}, bit_index, 0);
      chk({name, "_strb"},
          {start_strobe, shift_enable, stop_strobe, packet_done}, 0);
   endtask

   task automatic run_pkt(input int p, input int ds,
                          input bit two, input bit par);
      int k, done;
      bit_period = 14'(p);
      data_size  = 4'(ds);
      two_stop   = two;
`ifdef RX_BIT_TIMER_PARITY_EN
      parity_en  = par;
`endif
      enable_timer = 1'b1;
      k = cyc + 1;
      push_pkt(k, p, ds, two, par, done);
      go_to(done + 1);
      enable_timer = 1'b0;
      go_to(cyc + 4);
   endtask

   initial begin
      int k, done, p, ds;
      bit two, par;
      rst          = 1'b1;
      enable_timer = 1'b1;
      data_size    = 4'd8;
      bit_period   = 14'd10;
      two_stop     = 1'b0;
`ifdef RX_BIT_TIMER_PARITY_EN
      parity_en    = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_quiet("reset");
      @(posedge clk);
      #1;
      rst          = 1'b0;
      enable_timer = 1'b0;
      go_to(cyc + 3);

      run_pkt(10, 8, 1'b0, 1'b0);
      run_pkt(10, 8, 1'b1, 1'b0);
      run_pkt(1, 0, 1'b0, 1'b0);
`ifdef RX_BIT_TIMER_PARITY_EN
      run_pkt(10, 8, 1'b0, 1'b1);
`endif

      // Abort by dropping enable at cycle 40
      bit_period   = 14'd10;
      data_size    = 4'd8;
      two_stop     = 1'b0;
      enable_timer = 1'b1;
      k = cyc + 1;
      push_pkt(k, 10, 8, 1'b0, 1'b0, done);
      go_to(k + 40);
      enable_timer = 1'b0;
      purge_from(k + 40);
      @(posedge clk);
      @(negedge clk);
      chk_quiet("abort");
      @(posedge clk);
      #1;
      go_to(cyc + 100);

      // Reset at cycle 50 with enable held high
      enable_timer = 1'b1;
      k = cyc + 1;
      push_pkt(k, 10, 8, 1'b0, 1'b0, done);
      go_to(k + 50);
      rst = 1'b1;
      purge_from(k + 51);
      @(posedge clk);
      @(negedge clk);
      chk_quiet("rst_mid");
      @(posedge clk);
      #1;
      go_to(cyc + 3);
      rst = 1'b0;
      k = cyc + 1;
      push_pkt(k, 10, 8, 1'b0, 1'b0, done);
      go_to(done + 1);
      enable_timer = 1'b0;
      go_to(cyc + 4);

      // Random back-to-back packets with inputs scrambled mid-packet
      p   = $urandom_range(0, 12);
      ds  = $urandom_range(0, 15);
      two = 1'($urandom_range(0, 1));
      par = 1'b0;
`ifdef RX_BIT_TIMER_PARITY_EN
      par = 1'($urandom_range(0, 1));
      parity_en = par;
`endif
      bit_period   = 14'(p);
      data_size    = 4'(ds);
      two_stop     = two;
      enable_timer = 1'b1;
      k = cyc + 1;
      for (int n = 0; n < 20; n++) begin
         push_pkt(k, p, ds, two, par, done);
         go_to(k + 1);
         bit_period = 14'($urandom_range(0, 40));
         data_size  = 4'($urandom_range(0, 15));
         two_stop   = 1'($urandom_range(0, 1));
`ifdef RX_BIT_TIMER_PARITY_EN
         parity_en  = 1'($urandom_range(0, 1));
`endif
         go_to(done);
         p   = $urandom_range(0, 12);
         ds  = $urandom_range(0, 15);
         two = 1'($urandom_range(0, 1));
`ifdef RX_BIT_TIMER_PARITY_EN
         par = 1'($urandom_range(0, 1));
         parity_en = par;
`endif
         bit_period = 14'(p);
         data_size  = 4'(ds);
         two_stop   = two;
         k = done + 1;
      end
      go_to(done + 1);
      enable_timer = 1'b0;
      go_to(cyc + 30);

      while (q.size() > 0) begin
         ev_t e;
         e = q.pop_front();
         total++;
         bad++;
         $display("FAIL leftover kind=%0d @%0d: got none want event",
                  e.kind, e.cyc);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rx_bit_timer.md
RX_BIT_TIMER -- requirements
Module: rx_bit_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 14: width of bit_period and the phase counter.
REQ-002 SHALL have parameter SIZE_W, default 4: width of data_size and bit_index.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable_timer, input, 1: high runs a packet; low aborts.
REQ-006 SHALL have port data_size, input, SIZE_W: data bits per packet.
REQ-007 SHALL have port bit_period, input, CNT_W: clocks per bit (P).
REQ-008 SHALL have port two_stop, input, 1: 1 selects two stop bits, 0 selects one.
REQ-009 SHALL have port start_strobe, output, 1: one-cycle pulse at start-bit centre.
REQ-010 SHALL have port shift_enable, output, 1: one-cycle pulse at each data-bit centre.
REQ-011 SHALL have port stop_strobe, output, 1: one-cycle pulse at each stop-bit centre.
REQ-012 SHALL have port bit_index, output, SIZE_W: index of the data bit being strobed, LSB-first from 0.
REQ-013 SHALL have port packet_done, output, 1: one-cycle pulse on packet completion.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP and DONE; PARITY is added per REQ-030.
REQ-016 SHALL leave IDLE for START on the edge where enable_timer=1, latching data_size, bit_period and two_stop; later input changes are ignored until the next IDLE.
REQ-017 SHALL clamp latched values: P<2 becomes 2; data_size=0 becomes 1 (D).
REQ-018 SHALL, with enable sampled at edge k, assert start_strobe in cycle k+H, where H=P>>1 (minimum 1), then enter DATA.
REQ-019 SHALL assert shift_enable for data bit i (0..D-1) in cycle k+H+(i+1)*P, with bit_index=i in that cycle.
REQ-020 SHALL assert stop_strobe one P after the last data (or parity) strobe, and a second one P later when two_stop=1.
REQ-021 SHALL pulse packet_done in the DONE cycle immediately after the final stop_strobe, then return to IDLE.
REQ-022 SHALL restart from IDLE after one IDLE cycle if enable_timer is still high, giving back-to-back packets.
REQ-023 SHALL, on enable_timer=0 in any non-IDLE state, go to IDLE next edge with the phase counter and bit counter cleared, emit no strobe in the abort cycle, and never pulse packet_done.
REQ-024 SHALL keep strobes mutually exclusive; at most one strobe is high per cycle.
REQ-025 SHALL count the phase counter 1..terminal and reload to 1 on the strobe cycle; it SHALL never wrap through 0 at full scale (P=2^CNT_W-1 is legal).
REQ-026 SHALL hold bit_index at 0 outside DATA.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, enter IDLE and drive all strobes, packet_done, busy and bit_index to 0; rst has priority over enable_timer.
REQ-028 SHALL abort a packet on rst mid-packet exactly as in REQ-023.

Configuration
REQ-029 SHALL use macro RX_BIT_TIMER_PARITY_EN to compile parity support in or out.
REQ-030 SHALL, with the macro defined, add input parity_en (1 bit), output parity_strobe (1 bit) and state PARITY between DATA and STOP; when latched parity_en=1, parity_strobe pulses P after the last data strobe and stop timing shifts by P.
REQ-031 SHALL, without the macro, have no parity_en or parity_strobe ports and no PARITY state, with timing exactly per REQ-018 to REQ-021.

Structure
REQ-032 SHALL take the FSM state enum and the minimum-period and minimum-size constants from shared package rx_timer_pkg.
REQ-033 SHALL implement the phase counter as a sub-module bit_phase_counter (sync clear, enable, terminal value, terminal-reached flag), parametrised by CNT_W.

Verification
REQ-034 SHALL cover: P=10, D=8, one stop; enable at edge 0 -> start_strobe @5, shift_enable @15..85 step 10 with bit_index 0..7, stop_strobe @95, packet_done @96.
REQ-035 SHALL cover: P=10, D=8, two_stop=1 -> stop_strobe @95 and @105, packet_done @106.
REQ-036 SHALL cover: P=1, data_size=0 -> treated as P=2, D=1: start @1, shift @3, stop @5, done @6.
REQ-037 SHALL cover: enable dropped at cycle 40 of the REQ-034 packet -> busy=0 from 41, no further strobes, no packet_done.
REQ-038 SHALL cover: rst=1 at cycle 50 with enable high -> all outputs 0 next cycle; after rst release, a new packet starts from IDLE.
REQ-039 SHALL cover: macro defined, parity_en=1, P=10, D=8 -> parity_strobe @95, stop_strobe @105, packet_done @106.
